// File: rtl/piso_shift_reg_param.sv
// Parallel-in/serial-out shift register with a valid/ready load handshake,
// selectable bit order, shift pacing and gapless back-to-back frames.
module piso_shift_reg_param #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          LSB_FIRST  = 1'b0,
    parameter bit          IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             shift_en,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             busy,
    output logic             frame_done
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] shifted;
    logic             last_bit;
    logic             accept;

    assign last_bit   = (state == SHIFT) && (cnt == '0);
    // Ready on the last consumed bit too, so the next word follows with no gap.
    assign load_ready = (state == IDLE) || (last_bit && shift_en);
    assign accept     = load_valid && load_ready;
    assign shifted    = LSB_FIRST ? (shreg >> 1) : (shreg << 1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            shreg      <= '0;
            cnt        <= '0;
            frame_done <= 1'b0;
        end else begin
            // NOTE: non-blocking updates let every branch read this cycle's cnt/state.
            frame_done <= last_bit && shift_en;
            if (accept) begin
                shreg <= parallel_in;
                cnt   <= CNT_W'(WIDTH - 1);
                state <= SHIFT;
            end else if (state == SHIFT && shift_en) begin
                if (last_bit) begin
                    state <= IDLE;
                end else begin
                    shreg <= shifted;
                    cnt   <= cnt - CNT_W'(1);
                end
            end
        end
    end

    assign serial_out   = (state == SHIFT) ? (LSB_FIRST ? shreg[0] : shreg[WIDTH-1])
                                           : IDLE_LEVEL;
    assign serial_valid = (state == SHIFT);
    assign busy         = (state == SHIFT);

endmodule
